// File: rtl/ahb2apb_pkg.sv
// Shared types and helpers for the AHB-Lite to APB bridge.
package ahb2apb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPend,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } state_e;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransBusy   = 2'b01;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    // Only HPROT[1:0] carry information APB can express.
    function automatic logic [2:0] pprot_map(input logic [1:0] hprot_lo);
        return {~hprot_lo[0], 1'b0, hprot_lo[1]};
    endfunction

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ahb2apb_strb_gen.sv
// Write strobe generator: byte lanes covered by a transfer, plus oversize detection.
module ahb2apb_strb_gen
    import ahb2apb_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [2:0]           hsize,
    input  logic [clog2(NB)-1:0] addr_lo,
    output logic [NB-1:0]        strb,
    output logic                 sz_err
);

    localparam int unsigned LgNb = clog2(NB);

    int unsigned nbytes;
    int unsigned offset;

    always_comb begin
        sz_err = 32'(hsize) > LgNb;
        nbytes = 32'd1 << hsize;
        // Lane offset is the low address aligned down to the transfer size.
        offset = 32'(addr_lo) & ~(nbytes - 32'd1);
        strb   = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            strb[b] = !sz_err && (b >= offset) && (b < offset + nbytes);
        end
    end

endmodule

// File: rtl/ahb2apb_bridge_mc.sv
// AHB-Lite to APB bridge with multi-slave decode, APB3/APB4 signalling, PREADY watchdog
// and a two-cycle AHB ERROR response. APB timing is qualified by PCLKEN.
module ahb2apb_bridge_mc
    import ahb2apb_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = 16,
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned NUM_PSEL  = 4,
    parameter int unsigned SLV_LSB   = 12,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic                          HSEL,
    input  logic                          HREADY,
    input  logic                          HWRITE,
    input  logic [ADDRWIDTH-1:0]          HADDR,
    input  logic [1:0]                    HTRANS,
    input  logic [2:0]                    HSIZE,
    input  logic [3:0]                    HPROT,
    input  logic [DATAWIDTH-1:0]          HWDATA,
    output logic                          HREADYOUT,
    output logic                          HRESP,
    output logic [DATAWIDTH-1:0]          HRDATA,
    input  logic                          PCLKEN,
    output logic [NUM_PSEL-1:0]           PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDRWIDTH-1:0]          PADDR,
    output logic [DATAWIDTH-1:0]          PWDATA,
    output logic [DATAWIDTH/8-1:0]        PSTRB,
    output logic [2:0]                    PPROT,
    input  logic [NUM_PSEL*DATAWIDTH-1:0] PRDATA,
    input  logic [NUM_PSEL-1:0]           PREADY,
    input  logic [NUM_PSEL-1:0]           PSLVERR,
    output logic                          APBACTIVE
);

    localparam int unsigned NB   = DATAWIDTH / 8;
    localparam int unsigned LgNb = clog2(NB);
    localparam int unsigned SW   = (clog2(NUM_PSEL) < 1) ? 1 : clog2(NUM_PSEL);
    localparam int unsigned CW   = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [ADDRWIDTH-1:0] AddrMask = ~ADDRWIDTH'((32'd1 << LgNb) - 32'd1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          wdog_q, wdog_d;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic                   write_q;
    logic [SW-1:0]          idx_q;
    logic [2:0]             prot_q;
    logic [NB-1:0]          strb_q;
    logic [DATAWIDTH-1:0]   wdata_q;
    logic                   pend_first_q;
    logic [ADDRWIDTH-1:0]   paddr_q;
    logic                   pwrite_q;
    logic [2:0]             pprot_q;
    logic [NB-1:0]          pstrb_q;
    logic [DATAWIDTH-1:0]   pwdata_q;
    logic [DATAWIDTH-1:0]   hrdata_q;

    logic                   cap;
    logic                   bad;
    logic                   rd_done;
    logic [SW-1:0]          idx_in;
    logic [NB-1:0]          strb_in;
    logic                   sz_err;
    logic                   apb_sel;
    logic                   pready_sel;
    logic                   pslverr_sel;
    logic [DATAWIDTH-1:0]   prdata_sel;
    logic                   unused;

    assign unused = ^{HTRANS[0], HPROT[3:2]};
    assign idx_in = HADDR[SLV_LSB +: SW];

    ahb2apb_strb_gen #(
        .NB(NB)
    ) u_strb_gen (
        .hsize  (HSIZE),
        .addr_lo(HADDR[LgNb-1:0]),
        .strb   (strb_in),
        .sz_err (sz_err)
    );

    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int unsigned i = 0; i < NUM_PSEL; i++) begin
            if (idx_q == SW'(i)) begin
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
                prdata_sel  = PRDATA[i*DATAWIDTH +: DATAWIDTH];
            end
        end
    end

    always_comb begin
        cap     = HSEL && HREADY && HTRANS[1] && (state_q == StIdle || state_q == StErr2);
        bad     = (32'(idx_in) >= NUM_PSEL) || sz_err;
        state_d = state_q;
        wdog_d  = wdog_q;
        rd_done = 1'b0;
        unique case (state_q)
            StIdle, StErr2: begin
                if (cap) begin
                    state_d = bad ? StErr1 : StPend;
                end else begin
                    state_d = StIdle;
                end
            end
            StPend: begin
                if (PCLKEN) begin
                    state_d = StSetup;
                    wdog_d  = '0;
                end
            end
            StSetup: begin
                if (PCLKEN) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (PCLKEN) begin
                    if (pready_sel) begin
                        if (pslverr_sel) begin
                            state_d = StErr1;
                        end else begin
                            state_d = StIdle;
                            rd_done = !write_q;
                        end
                    end else if (TIMEOUT != 0) begin
                        wdog_d = wdog_q + CW'(1);
                        if (wdog_d == CW'(TIMEOUT)) begin
                            state_d = StErr1;
                        end
                    end
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= StIdle;
            wdog_q       <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            prot_q       <= '0;
            strb_q       <= '0;
            wdata_q      <= '0;
            pend_first_q <= 1'b0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pprot_q      <= '0;
            pstrb_q      <= '0;
            pwdata_q     <= '0;
            hrdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            pend_first_q <= cap && (state_d == StPend);
            if (cap) begin
                addr_q  <= HADDR & AddrMask;
                write_q <= HWRITE;
                idx_q   <= idx_in;
                prot_q  <= pprot_map(HPROT[1:0]);
                strb_q  <= HWRITE ? strb_in : '0;
            end
            if (pend_first_q) begin
                wdata_q <= HWDATA;
            end
            // APB-facing copies only move on the PCLKEN edge that enters SETUP.
            if (state_q == StPend && PCLKEN) begin
                paddr_q  <= addr_q;
                pwrite_q <= write_q;
                pprot_q  <= prot_q;
                pstrb_q  <= strb_q;
                if (write_q) begin
                    pwdata_q <= pend_first_q ? HWDATA : wdata_q;
                end
            end
            if (rd_done) begin
                hrdata_q <= prdata_sel;
            end
        end
    end

    assign apb_sel = (state_q == StSetup) || (state_q == StAccess);

    always_comb begin
        PSEL = '0;
        for (int unsigned i = 0; i < NUM_PSEL; i++) begin
            PSEL[i] = apb_sel && (idx_q == SW'(i));
        end
    end

    always_comb begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b0;
        unique case (state_q)
            StIdle: HREADYOUT = 1'b1;
            StErr1: HRESP = 1'b1;
            StErr2: begin
                HREADYOUT = 1'b1;
                HRESP     = 1'b1;
            end
            default: ;
        endcase
    end

    assign PENABLE   = (state_q == StAccess);
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PPROT     = pprot_q;
    assign PSTRB     = pstrb_q;
    assign PWDATA    = pwdata_q;
    assign HRDATA    = hrdata_q;
    assign APBACTIVE = (state_q != StIdle);

endmodule

// File: tb/tb_ahb2apb_bridge_mc.sv
// Directed bench for ahb2apb_bridge_mc: a 4-slave bridge with an 8-cycle watchdog and a
// 3-slave bridge for out-of-range decode.
module tb_ahb2apb_bridge_mc;

    logic         hclk, hreset;
    logic         hsel, hsel_b, hwrite;
    logic [15:0]  haddr;
    logic [1:0]   htrans;
    logic [2:0]   hsize;
    logic [3:0]   hprot;
    logic [31:0]  hwdata;
    logic         pclken;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;

    logic         hreadyout, hresp, penable, pwrite, apbactive;
    logic [31:0]  hrdata, pwdata;
    logic [3:0]   psel, pstrb;
    logic [15:0]  paddr;
    logic [2:0]   pprot;

    logic         hreadyout_b, hresp_b, penable_b, pwrite_b, apbactive_b;
    logic [31:0]  hrdata_b, pwdata_b;
    logic [2:0]   psel_b, pprot_b;
    logic [3:0]   pstrb_b;
    logic [15:0]  paddr_b;

    // {HREADYOUT, HRESP, APBACTIVE, PSEL, PENABLE}
    logic [7:0]   st;
    logic [6:0]   st_b;
    assign st   = {hreadyout, hresp, apbactive, psel, penable};
    assign st_b = {hreadyout_b, hresp_b, apbactive_b, psel_b, penable_b};

    int  vectors;
    int  miscompares;
    logic div_mode;
    logic pen_edge;

    ahb2apb_bridge_mc #(
        .ADDRWIDTH(16), .DATAWIDTH(32), .NUM_PSEL(4), .SLV_LSB(12), .TIMEOUT(8)
    ) dut (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HREADY(hreadyout), .HWRITE(hwrite),
        .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .PCLKEN(pclken),
        .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PSTRB(pstrb), .PPROT(pprot), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr),
        .APBACTIVE(apbactive)
    );

    ahb2apb_bridge_mc #(
        .ADDRWIDTH(16), .DATAWIDTH(32), .NUM_PSEL(3), .SLV_LSB(12), .TIMEOUT(0)
    ) dut_b (
        .HCLK(hclk), .HRESET(hreset), .HSEL(hsel_b), .HREADY(hreadyout_b), .HWRITE(hwrite),
        .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HPROT(hprot), .HWDATA(hwdata),
        .HREADYOUT(hreadyout_b), .HRESP(hresp_b), .HRDATA(hrdata_b), .PCLKEN(pclken),
        .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PADDR(paddr_b),
        .PWDATA(pwdata_b), .PSTRB(pstrb_b), .PPROT(pprot_b), .PRDATA(96'd0),
        .PREADY(3'b111), .PSLVERR(3'b000), .APBACTIVE(apbactive_b)
    );

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    task automatic tick();
        pen_edge = pclken;
        @(posedge hclk);
        #1;
        if (div_mode) pclken = ~pclken;
    endtask

    task automatic addr_phase(input logic wr, input logic [15:0] a, input logic [2:0] sz,
                              input logic to_b);
        hsel   = !to_b;
        hsel_b = to_b;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        hsel_b = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        #3;
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL reset_status got %b want 10000000", st);
        end
        vectors++;
        if ({paddr, pwdata, pstrb, pprot, pwrite, hrdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got paddr=%h pwdata=%h pstrb=%h pprot=%h hrdata=%h",
                     paddr, pwdata, pstrb, pprot, hrdata);
        end
        tick();
        tick();
        hreset = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        addr_phase(1'b1, 16'h1008, 3'd2, 1'b0);
        tick();
        bus_idle();
        hwdata = 32'hDEADBEEF;
        vectors++;
        if (st !== 8'b0_0_1_0000_0) begin
            miscompares++; $display("FAIL wr_pend got %b want 00100000", st);
        end
        tick();
        hwdata = 32'h0;
        vectors++;
        if (st !== 8'b0_0_1_0010_0) begin
            miscompares++; $display("FAIL wr_setup got %b want 00100100", st);
        end
        vectors++;
        if ({paddr, pstrb, pwdata, pwrite, pprot} !== {16'h1008, 4'hF, 32'hDEADBEEF, 1'b1, 3'b001})
        begin
            miscompares++;
            $display("FAIL wr_apb got paddr=%h pstrb=%h pwdata=%h pwrite=%b pprot=%b",
                     paddr, pstrb, pwdata, pwrite, pprot);
        end
        tick();
        vectors++;
        if (st !== 8'b0_0_1_0010_1) begin
            miscompares++; $display("FAIL wr_access got %b want 00100101", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL wr_done got %b want 10000000", st);
        end
    endtask

    task automatic test_byte_read_div2();
        logic [58:0] prev, cur;
        int  acc;
        logic seen_setup, done;
        prdata[3*32 +: 32] = 32'h11223344;
        pready[3]  = 1'b0;
        div_mode   = 1'b1;
        pclken     = 1'b0;
        acc        = 0;
        seen_setup = 1'b0;
        done       = 1'b0;
        prev = {psel, penable, pwrite, paddr, pstrb, pprot, pwdata};
        addr_phase(1'b0, 16'h3003, 3'd0, 1'b0);
        for (int c = 0; c < 60 && !done; c++) begin
            if (penable && pclken) begin
                pready[3] = (acc >= 2);
                acc++;
            end
            tick();
            if (c == 0) bus_idle();
            cur = {psel, penable, pwrite, paddr, pstrb, pprot, pwdata};
            if (!pen_edge) begin
                vectors++;
                if (cur !== prev) begin
                    miscompares++; $display("FAIL rd_pclken_hold got %h want %h", cur, prev);
                end
            end
            prev = cur;
            if (psel != 4'b0 && !penable && !seen_setup) begin
                seen_setup = 1'b1;
                vectors++;
                if ({psel, pstrb, paddr, pwrite} !== {4'b1000, 4'h0, 16'h3000, 1'b0}) begin
                    miscompares++;
                    $display("FAIL rd_setup got psel=%b pstrb=%h paddr=%h pwrite=%b",
                             psel, pstrb, paddr, pwrite);
                end
            end
            if (hreadyout) done = 1'b1;
        end
        vectors++;
        if (!done || !seen_setup) begin
            miscompares++; $display("FAIL rd_timeout got done=%b setup=%b want 1 1", done, seen_setup);
        end
        vectors++;
        if ({hrdata, hresp} !== {32'h11223344, 1'b0}) begin
            miscompares++; $display("FAIL rd_data got %h/%b want 11223344/0", hrdata, hresp);
        end
        div_mode  = 1'b0;
        pclken    = 1'b1;
        pready[3] = 1'b1;
        tick();
    endtask

    task automatic test_pslverr();
        pslverr[1] = 1'b1;
        addr_phase(1'b1, 16'h1000, 3'd2, 1'b0);
        tick();
        bus_idle();
        hwdata = 32'h01020304;
        tick();
        tick();
        tick();
        vectors++;
        if (st !== 8'b0_1_1_0000_0) begin
            miscompares++; $display("FAIL slverr_err1 got %b want 01100000", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_1_1_0000_0) begin
            miscompares++; $display("FAIL slverr_err2 got %b want 11100000", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL slverr_idle got %b want 10000000", st);
        end
        vectors++;
        if (hrdata !== 32'h11223344) begin
            miscompares++; $display("FAIL hrdata_hold got %h want 11223344", hrdata);
        end
        pslverr[1] = 1'b0;
    endtask

    task automatic test_timeout();
        int acc;
        pready = 4'h0;
        addr_phase(1'b1, 16'h2004, 3'd2, 1'b0);
        tick();
        bus_idle();
        tick();
        tick();
        acc = 0;
        while (penable && acc < 20) begin
            vectors++;
            if (st !== 8'b0_0_1_0100_1) begin
                miscompares++; $display("FAIL to_access got %b want 00101001", st);
            end
            acc++;
            tick();
        end
        vectors++;
        if (acc !== 8) begin
            miscompares++; $display("FAIL to_count got %0d want 8", acc);
        end
        vectors++;
        if (st !== 8'b0_1_1_0000_0) begin
            miscompares++; $display("FAIL to_err1 got %b want 01100000", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_1_1_0000_0) begin
            miscompares++; $display("FAIL to_err2 got %b want 11100000", st);
        end
        tick();
        pready = 4'hF;
    endtask

    task automatic test_decode_size_err();
        addr_phase(1'b1, 16'h3000, 3'd2, 1'b1);
        tick();
        bus_idle();
        vectors++;
        if (st_b !== 7'b0_1_1_000_0) begin
            miscompares++; $display("FAIL dec_err1 got %b want 0110000", st_b);
        end
        tick();
        vectors++;
        if (st_b !== 7'b1_1_1_000_0) begin
            miscompares++; $display("FAIL dec_err2 got %b want 1110000", st_b);
        end
        tick();
        vectors++;
        if (st_b !== 7'b1_0_0_000_0) begin
            miscompares++; $display("FAIL dec_idle got %b want 1000000", st_b);
        end
        addr_phase(1'b1, 16'h1000, 3'd3, 1'b0);
        tick();
        bus_idle();
        vectors++;
        if (st !== 8'b0_1_1_0000_0) begin
            miscompares++; $display("FAIL size_err1 got %b want 01100000", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_1_1_0000_0) begin
            miscompares++; $display("FAIL size_err2 got %b want 11100000", st);
        end
        tick();
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL size_idle got %b want 10000000", st);
        end
    endtask

    task automatic test_reset_mid_access();
        pready = 4'h0;
        addr_phase(1'b1, 16'h1000, 3'd2, 1'b0);
        tick();
        bus_idle();
        tick();
        tick();
        vectors++;
        if (st !== 8'b0_0_1_0010_1) begin
            miscompares++; $display("FAIL rst_pre got %b want 00100101", st);
        end
        #2;
        hreset = 1'b1;
        #1;
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL rst_async got %b want 10000000", st);
        end
        tick();
        hreset = 1'b0;
        pready = 4'hF;
        tick();
    endtask

    task automatic test_back_to_back();
        prdata[1*32 +: 32] = 32'h55667788;
        addr_phase(1'b1, 16'h2006, 3'd1, 1'b0);
        tick();
        bus_idle();
        hwdata = 32'hCAFEF00D;
        tick();
        vectors++;
        if ({st, paddr, pstrb, pwdata, pwrite} !==
            {8'b0_0_1_0100_0, 16'h2004, 4'b1100, 32'hCAFEF00D, 1'b1}) begin
            miscompares++;
            $display("FAIL b2b_wr_setup got st=%b paddr=%h pstrb=%b pwdata=%h pwrite=%b",
                     st, paddr, pstrb, pwdata, pwrite);
        end
        tick();
        tick();
        vectors++;
        if (st !== 8'b1_0_0_0000_0) begin
            miscompares++; $display("FAIL b2b_wr_done got %b want 10000000", st);
        end
        addr_phase(1'b0, 16'h1004, 3'd2, 1'b0);
        tick();
        bus_idle();
        vectors++;
        if (st !== 8'b0_0_1_0000_0) begin
            miscompares++; $display("FAIL b2b_rd_pend got %b want 00100000", st);
        end
        tick();
        vectors++;
        if ({st, paddr, pstrb, pwrite} !== {8'b0_0_1_0010_0, 16'h1004, 4'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL b2b_rd_setup got st=%b paddr=%h pstrb=%h pwrite=%b",
                     st, paddr, pstrb, pwrite);
        end
        tick();
        tick();
        vectors++;
        if ({st, hrdata} !== {8'b1_0_0_0000_0, 32'h55667788}) begin
            miscompares++; $display("FAIL b2b_rd_done got st=%b hrdata=%h", st, hrdata);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        div_mode    = 1'b0;
        pen_edge    = 1'b1;
        hreset      = 1'b1;
        hsel        = 1'b0;
        hsel_b      = 1'b0;
        hwrite      = 1'b0;
        haddr       = 16'h0;
        htrans      = 2'b00;
        hsize       = 3'd0;
        hprot       = 4'b0011;
        hwdata      = 32'h0;
        pclken      = 1'b1;
        prdata      = '0;
        pready      = 4'hF;
        pslverr     = 4'h0;

        test_reset();
        test_single_write();
        test_byte_read_div2();
        test_pslverr();
        test_timeout();
        test_decode_size_err();
        test_reset_mid_access();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
